// File: rtl/iterative_multiplier_if.sv
// Issue/result bundle between the execute stage and the iterative multiplier.
// The pipeline side is the master; the multiply unit is the slave.
interface iterative_multiplier_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            ALU_op;
  logic [DATA_WIDTH-1:0] operand_A;
  logic [DATA_WIDTH-1:0] operand_B;
  logic [4:0]            rd_in;
  logic                  flush;
  logic                  stall_MULT;
  logic                  busy;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;
  logic [4:0]            rd_out;

  modport master (
    output start, ALU_op, operand_A, operand_B, rd_in, flush,
    input  stall_MULT, busy, result, result_valid, rd_out
  );

  modport slave (
    input  start, ALU_op, operand_A, operand_B, rd_in, flush,
    output stall_MULT, busy, result, result_valid, rd_out
  );
endinterface

// File: rtl/iterative_multiplier.sv
// Radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one multiplier
// bit per cycle, with a zero-operand early-out and flush abort.
//
// state | meaning
// IDLE  | waiting for an accepted M-extension multiply
// BUSY  | shift-add iterations, one multiplier bit per cycle
// DONE  | result_valid pulse, result/rd_out presented
module iterative_multiplier #(
  parameter int DATA_WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset,
  iterative_multiplier_if.slave mul
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [2*DW-1:0] acc;
  logic [DW-1:0] mcand;
  logic [CW-1:0] count;
  logic          neg;
  logic          want_high;
  logic [4:0]    rd_q;
  logic [4:0]    rd_out_q;
  logic [DW-1:0] result_q;

  logic          accept;
  logic          signed_a, signed_b;
  logic          sign_a, sign_b;
  logic [DW-1:0] mag_a, mag_b;
  logic [DW:0]   partial;
  logic [2*DW-1:0] acc_next;
  logic [2*DW-1:0] final_prod;

  assign accept   = (state == IDLE) && mul.start && !mul.ALU_op[2] && !mul.flush;
  assign signed_a = (mul.ALU_op[1:0] == 2'b01) || (mul.ALU_op[1:0] == 2'b10);
  assign signed_b = (mul.ALU_op[1:0] == 2'b01);
  assign sign_a   = signed_a && mul.operand_A[DW-1];
  assign sign_b   = signed_b && mul.operand_B[DW-1];
  assign mag_a    = sign_a ? -mul.operand_A : mul.operand_A;
  assign mag_b    = sign_b ? -mul.operand_B : mul.operand_B;

  // Upper half plus multiplicand keeps its carry so the shift brings it down.
  assign partial    = {1'b0, acc[2*DW-1:DW]} + ({1'b0, mcand} & {(DW+1){acc[0]}});
  assign acc_next   = {partial, acc[DW-1:1]};
  assign final_prod = neg ? -acc_next : acc_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      count     <= '0;
      neg       <= 1'b0;
      want_high <= 1'b0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      result_q  <= '0;
    end else if (mul.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            want_high <= (mul.ALU_op[1:0] != 2'b00);
            rd_q      <= mul.rd_in;
            neg       <= sign_a ^ sign_b;
            mcand     <= mag_a;
            acc       <= {{DW{1'b0}}, mag_b};
            count     <= '0;
            if (mul.operand_A == '0 || mul.operand_B == '0) begin
              state    <= DONE;
              result_q <= '0;
              rd_out_q <= mul.rd_in;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == CW'(DATA_WIDTH - 1)) begin
            state    <= DONE;
            result_q <= want_high ? final_prod[2*DW-1:DW] : final_prod[DW-1:0];
            rd_out_q <= rd_q;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mul.stall_MULT   = (state == BUSY) || accept;
  assign mul.busy         = (state != IDLE);
  assign mul.result_valid = (state == DONE) && !mul.flush;
  assign mul.result       = result_q;
  assign mul.rd_out       = rd_out_q;
endmodule
